// File: rtl/corrige_hamming_pkg.sv
// rtl/corrige_hamming_pkg.sv - shared Hamming(15,11) constants and helpers
// Coverage masks and data positions are shared with the encoder side of the link.
package pkg_hamming;

  localparam int LARGURA_DADO = 11;
  localparam int LARGURA_CW   = 15;
  localparam int LARGURA_SIND = 4;

  // Bit k-1 of a mask is set when Hamming position k is covered by that parity bit.
  localparam logic [LARGURA_CW-1:0] MASCARA_P1 = 15'h5555;
  localparam logic [LARGURA_CW-1:0] MASCARA_P2 = 15'h6666;
  localparam logic [LARGURA_CW-1:0] MASCARA_P4 = 15'h7878;
  localparam logic [LARGURA_CW-1:0] MASCARA_P8 = 15'h7F80;

  localparam int POS_DADO [0:LARGURA_DADO-1] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

  function automatic logic [LARGURA_DADO-1:0] extrai_dados(input logic [LARGURA_CW-1:0] cw);
    logic [LARGURA_DADO-1:0] d;
    d = '0;
    for (int i = 0; i < LARGURA_DADO; i++) begin
      d[i] = cw[POS_DADO[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/corrige_hamming_sindrome.sv
// rtl/corrige_hamming_sindrome.sv - combinational Hamming(15,11) syndrome
// A nonzero result is the 1-based position of a single flipped bit.
module sindrome_hamming
  import pkg_hamming::*;
(
  input  logic [LARGURA_CW-1:0]   cw,
  output logic [LARGURA_SIND-1:0] sindrome
);

  assign sindrome = {^(cw & MASCARA_P8),
                     ^(cw & MASCARA_P4),
                     ^(cw & MASCARA_P2),
                     ^(cw & MASCARA_P1)};

endmodule

// File: rtl/corrige_hamming.sv
// rtl/corrige_hamming.sv - two-stage Hamming(15,11) single-error corrector
// Stage 1 registers codeword and syndrome; stage 2 registers corrected data.
module corrige_hamming
  import pkg_hamming::*;
#(
  parameter int LARGURA_CONT = 16
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LARGURA_CW-1:0]   entrada,
  input  logic                    entrada_valida,
  output logic                    entrada_pronta,
  output logic [LARGURA_DADO-1:0] saida,
  output logic [LARGURA_SIND-1:0] sindrome,
  output logic                    erro,
  output logic                    saida_valida,
  input  logic                    saida_pronta,
  input  logic                    limpa_contador,
  output logic [LARGURA_CONT-1:0] cont_corrigidos
);

  logic [LARGURA_CW-1:0]   cw1;
  logic [LARGURA_SIND-1:0] s1;
  logic [LARGURA_SIND-1:0] s_calc;
  logic [LARGURA_CW-1:0]   mascara_erro;
  logic [LARGURA_CW-1:0]   corrigido;
  logic                    v1;
  logic                    v2;
  logic                    adv2;
  logic                    in_fire;
  logic                    out_fire;

  sindrome_hamming u_sindrome (
    .cw       (entrada),
    .sindrome (s_calc)
  );

  assign adv2           = v1 & (~v2 | saida_pronta);
  assign entrada_pronta = ~v1 | adv2;
  assign in_fire        = entrada_valida & entrada_pronta;
  assign out_fire       = v2 & saida_pronta;
  assign saida_valida   = v2;

  // Zero syndrome means no flip; otherwise flip position s1 (bit s1-1).
  always_comb begin
    mascara_erro = '0;
    if (s1 != '0) begin
      mascara_erro = LARGURA_CW'(1) << (s1 - 4'd1);
    end
    corrigido = cw1 ^ mascara_erro;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw1             <= '0;
      s1              <= '0;
      v1              <= 1'b0;
      v2              <= 1'b0;
      saida           <= '0;
      sindrome        <= '0;
      erro            <= 1'b0;
      cont_corrigidos <= '0;
    end else begin
      if (in_fire) begin
        cw1 <= entrada;
        s1  <= s_calc;
        v1  <= 1'b1;
      end else if (adv2) begin
        v1  <= 1'b0;
      end

      if (adv2) begin
        saida    <= extrai_dados(corrigido);
        sindrome <= s1;
        erro     <= (s1 != '0);
        v2       <= 1'b1;
      end else if (out_fire) begin
        v2       <= 1'b0;
      end

      // Clear wins over a simultaneous increment; count saturates at all-ones.
      if (limpa_contador) begin
        cont_corrigidos <= '0;
      end else if (out_fire && erro && (cont_corrigidos != '1)) begin
        cont_corrigidos <= cont_corrigidos + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_corrige_hamming.sv
// tb/tb_corrige_hamming.sv - scoreboard bench for corrige_hamming
// Stimulus pushes expected words; a negedge monitor pops and compares on every out_fire.
module tb_corrige_hamming;

  localparam int LC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [14:0]   entrada = '0;
  logic          entrada_valida = 1'b0;
  logic          entrada_pronta;
  logic [10:0]   saida;
  logic [3:0]    sindrome;
  logic          erro;
  logic          saida_valida;
  logic          saida_pronta = 1'b0;
  logic          limpa_contador = 1'b0;
  logic [LC-1:0] cont_corrigidos;

  corrige_hamming #(.LARGURA_CONT(LC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .entrada         (entrada),
    .entrada_valida  (entrada_valida),
    .entrada_pronta  (entrada_pronta),
    .saida           (saida),
    .sindrome        (sindrome),
    .erro            (erro),
    .saida_valida    (saida_valida),
    .saida_pronta    (saida_pronta),
    .limpa_contador  (limpa_contador),
    .cont_corrigidos (cont_corrigidos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] d;
    logic [3:0]  s;
    logic        e;
  } exp_t;

  exp_t          sb[$];
  exp_t          item;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [LC-1:0] exp_cnt = '0;
  logic          hold_v = 1'b0;
  logic [15:0]   hold_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: counter model, hold stability and in-order scoreboard compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cnt = '0;
      hold_v  = 1'b0;
    end else begin
      chk("cont_corrigidos", 32'(cont_corrigidos), 32'(exp_cnt));
      if (hold_v && saida_valida) begin
        chk("hold_stable", 32'({saida, sindrome, erro}), 32'(hold_val));
      end
      if (saida_valida && saida_pronta) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got saida %0h with empty scoreboard", saida);
        end else begin
          item = sb.pop_front();
          chk("saida", 32'(saida), 32'(item.d));
          chk("sindrome", 32'(sindrome), 32'(item.s));
          chk("erro", 32'(erro), 32'(item.e));
          if (!limpa_contador && item.e && exp_cnt != {LC{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        end
      end
      if (limpa_contador) exp_cnt = '0;
      hold_v   = saida_valida && !saida_pronta;
      hold_val = {saida, sindrome, erro};
    end
  end

  task automatic send(input logic [14:0] cw, input logic [10:0] d, input logic [3:0] s, input logic e);
    exp_t x;
    logic fired;
    int   i;
    x.d = d; x.s = s; x.e = e;
    entrada        = cw;
    entrada_valida = 1'b1;
    fired = 1'b0;
    for (i = 0; i < 200 && !fired; i++) begin
      @(negedge clk);
      fired = entrada_pronta;
      if (fired) sb.push_back(x);
      @(posedge clk);
      #1;
    end
    if (!fired) chk("send_timeout", 32'(fired), 32'd1);
  endtask

  task automatic idle();
    entrada_valida = 1'b0;
    entrada        = 15'h0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_saida_valida", 32'(saida_valida), 32'd0);
    chk("rst_saida", 32'(saida), 32'd0);
    chk("rst_sindrome", 32'(sindrome), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    chk("rst_cont", 32'(cont_corrigidos), 32'd0);
    chk("rst_entrada_pronta", 32'(entrada_pronta), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saida_pronta = 1'b1;

    // Directed words: clean, data error, parity error, all-zero, all-one, double error.
    send(15'h552D, 11'h555, 4'd0, 1'b0);
    send(15'h556D, 11'h555, 4'd7, 1'b1);
    send(15'h552C, 11'h555, 4'd1, 1'b1);
    send(15'h0000, 11'h000, 4'd0, 1'b0);
    send(15'h7FFF, 11'h7FF, 4'd0, 1'b0);
    send(15'h552E, 11'h554, 4'd3, 1'b1);
    idle();
    drain();

    // Every single-bit flip of the clean word restores 11'h555.
    for (int k = 1; k <= 15; k++) begin
      logic [14:0] cw;
      cw = 15'h552D ^ (15'h1 << (k - 1));
      send(cw, 11'h555, 4'(k), 1'b1);
    end
    idle();
    drain();

    // Backpressure: two accepted, then entrada_pronta held low until release.
    @(posedge clk); #1;
    saida_pronta = 1'b0;
    fork
      begin
        send(15'h552C, 11'h555, 4'd1, 1'b1);
        send(15'h552F, 11'h555, 4'd2, 1'b1);
        send(15'h5529, 11'h555, 4'd3, 1'b1);
        send(15'h5525, 11'h555, 4'd4, 1'b1);
        idle();
      end
      begin
        for (int i = 0; i < 3; i++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_entrada_pronta", 32'(entrada_pronta), 32'd0);
          chk("bp_scoreboard_depth", 32'(sb.size()), 32'd2);
        end
        @(posedge clk); #1;
        saida_pronta = 1'b1;
      end
    join
    drain();

    // Saturation with a 4-bit counter: 19 erroneous words pin it at 4'hF.
    for (int i = 0; i < 19; i++) send(15'h556D, 11'h555, 4'd7, 1'b1);
    idle();
    drain();
    @(negedge clk);
    chk("cont_saturated", 32'(cont_corrigidos), 32'hF);

    // Clear in the same cycle as an erroneous out_fire yields 0.
    @(posedge clk); #1;
    saida_pronta = 1'b0;
    send(15'h552C, 11'h555, 4'd1, 1'b1);
    idle();
    for (int i = 0; i < 20 && !saida_valida; i++) @(negedge clk);
    chk("limpa_wait_valid", 32'(saida_valida), 32'd1);
    @(posedge clk); #1;
    saida_pronta   = 1'b1;
    limpa_contador = 1'b1;
    @(posedge clk); #1;
    limpa_contador = 1'b0;
    @(negedge clk);
    chk("cont_cleared", 32'(cont_corrigidos), 32'd0);
    drain();

    // Async reset with both stages full and a nonzero counter.
    send(15'h556D, 11'h555, 4'd7, 1'b1);
    send(15'h552C, 11'h555, 4'd1, 1'b1);
    idle();
    drain();
    @(posedge clk); #1;
    saida_pronta = 1'b0;
    send(15'h556D, 11'h555, 4'd7, 1'b1);
    send(15'h552D, 11'h555, 4'd0, 1'b0);
    idle();
    @(negedge clk);
    chk("pre_rst_cont", 32'(cont_corrigidos), 32'd2);
    chk("pre_rst_valid", 32'(saida_valida), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_valid", 32'(saida_valida), 32'd0);
    chk("async_rst_cont", 32'(cont_corrigidos), 32'd0);
    chk("async_rst_pronta", 32'(entrada_pronta), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saida_pronta = 1'b1;

    // Two-cycle latency of the first word after reset.
    item.d = 11'h7FF; item.s = 4'd0; item.e = 1'b0;
    entrada        = 15'h7FFF;
    entrada_valida = 1'b1;
    @(negedge clk);
    chk("lat_entrada_pronta", 32'(entrada_pronta), 32'd1);
    sb.push_back(item);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(saida_valida), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(saida_valida), 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/corrige_hamming.md
Name: corrige_hamming

Overview:
- Downstream stage of the Hamming(15,11) encoder.
- Accepts 15-bit codewords over a valid/ready handshake and computes the 4-bit syndrome.
- Corrects any single-bit error and extracts the 11 data bits.
- Two-stage registered pipeline with backpressure, plus a saturating count of corrected words for link-health monitoring.

Parameters:
- LARGURA_CONT, 16, width of the corrected-word counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- entrada  input  15  codeword; bit k-1 = Hamming position k (P1 at bit 0, P2 bit 1, P4 bit 3, P8 bit 7, data D1..D11 at bits 2,4,5,6,8..14).
- entrada_valida  input  1  entrada is valid this cycle.
- entrada_pronta  output  1  stage can accept a codeword this cycle.
- saida  output  11  corrected data D1..D11 (saida[0] = D1).
- sindrome  output  4  syndrome of the word on saida.
- erro  output  1  sindrome != 0 (a bit was flipped back).
- saida_valida  output  1  saida/sindrome/erro are valid.
- saida_pronta  input  1  consumer accepts output.
- limpa_contador  input  1  synchronous clear of cont_corrigidos.
- cont_corrigidos  output  LARGURA_CONT  number of delivered words with erro = 1, saturating.

Behaviour:
- Reset (rst_n = 0, async): v1 = v2 = 0, saida_valida = 0, saida = 0, sindrome = 0, erro = 0, cont_corrigidos = 0. Reset mid-operation drops all in-flight words.
- Transfer rules: in_fire = entrada_valida & entrada_pronta; out_fire = saida_valida & saida_pronta.
- Stage 1 (S1), loaded on in_fire:
  - cw1 <= entrada; v1 <= 1.
  - s1 <= syndrome, where s[0] = XOR of bits {0,2,4,6,8,10,12,14}, s[1] = XOR {1,2,5,6,9,10,13,14}, s[2] = XOR {3,4,5,6,11,12,13,14}, s[3] = XOR {7..14}.
- Stage 2 (S2), loaded when S1 advances:
  - If s1 != 0, flip bit (s1-1) of cw1; otherwise pass unchanged.
  - saida <= data bits of the result; sindrome <= s1; erro <= (s1 != 0); v2 <= 1.
- Advance conditions:
  - adv2 = v1 & (!v2 | saida_pronta).
  - entrada_pronta = !v1 | adv2 (combinational from saida_pronta; no registered skid).
  - If S1 advances with no in_fire in the same cycle, v1 <= 0.
  - If out_fire with no adv2, v2 <= 0.
- saida_valida = v2. Output registers hold stable while saida_valida = 1 and saida_pronta = 0.
- Latency: 2 cycles from in_fire to saida_valida with no stall. Throughput is 1 word/cycle when saida_pronta is held at 1.
- Simultaneous in_fire and S1 advance in one cycle: S1 takes the new word and v1 stays 1.
- Double-bit errors are undetectable (no overall parity bit). They produce a nonzero syndrome and a miscorrection; this is the defined behaviour.
- Counter:
  - On out_fire with erro = 1, increment by 1, saturating at all-ones (no wrap).
  - limpa_contador has priority: a clear and an increment in the same cycle yield 0.
- Inputs sampled only on in_fire; entrada contents are don't-care otherwise.

Decomposition:
- Shared package pkg_hamming holds:
  - Constants LARGURA_DADO = 11, LARGURA_CW = 15, LARGURA_SIND = 4.
  - The four position masks for P1/P2/P4/P8 coverage (15'h5555, 15'h6666, 15'h7878, 15'h7F80), also usable by the encoder.
  - The data-position index list.
- One natural sub-module, sindrome_hamming: purely combinational, 15-bit codeword in, 4-bit syndrome out. Instantiated in S1; reusable by a future encoder self-check.

Test Plan:
- Clean word: entrada = 15'h552D (encoding of 11'h555) with saida_pronta = 1 -> 2 cycles later saida = 11'h555, sindrome = 0, erro = 0, counter unchanged.
- Data error: 15'h556D (bit 6 / D4 flipped) -> saida = 11'h555, sindrome = 7, erro = 1; counter +1 after out_fire.
- Parity error: 15'h552C (P1 flipped) -> saida = 11'h555, sindrome = 1, erro = 1. Sweep all 15 single flips of 15'h552D -> always 11'h555 with sindrome = flip position.
- Backpressure: stream 4 words with saida_pronta = 0 -> entrada_pronta drops after 2 accepted. Outputs hold stable. Releasing saida_pronta drains all 4 in order with no loss or duplication.
- Counter: drive 2^LARGURA_CONT + 3 erroneous words -> cont_corrigidos stays at all-ones. Pulse limpa_contador in the same cycle as an erroneous out_fire -> 0.
- Reset: assert rst_n = 0 asynchronously with both stages full -> saida_valida = 0 immediately and counter = 0. After release, the first new word emerges after 2 cycles.
